fan_pwm_driver: RTL

Downstream consumer of the thermal manager's `fan_speed` command. It turns the 8-bit target into a glitch-free PWM fan drive with a startup kick and rate-limited ramping. It also monitors the fan tachometer and forces the fan to full speed on a stall fault. It sits between the thermal management logic and the fan pin.

---
 rtl/fan_pwm_driver.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fan_pwm_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fan_pwm_driver
//
// Turns the thermal manager's 8-bit fan_speed command into a glitch-free PWM
// fan drive. A new fan is spun up with a full-duty kick, then the duty is
// ramped toward the target by a bounded step once per PWM period. The fan tach
// is counted over a window of PWM periods; a window with no tach edges while
// running latches a stall fault that forces the fan to full speed until
// fault_clear.
//
// Ports
//   clk           in   1  sole clock
//   rst           in   1  synchronous, active-high reset
//   fan_speed     in   8  target duty (0x00 off, 0xFF always on)
//   enable        in   1  0 forces the effective target to 0x00
//   tach_in       in   1  raw tach pulse, asynchronous to clk
//   fault_clear   in   1  single-cycle pulse, only acts in FAULT
//   fan_pwm       out  1  registered PWM drive
//   duty_current  out  8  duty in effect for the current PWM period
//   tach_count    out  8  tach edges in the last completed window (saturating)
//   fan_fault     out  1  high while in FAULT
// -----------------------------------------------------------------------------
module fan_pwm_driver #(
    parameter int PRESCALE     = 4,
    parameter int RAMP_STEP    = 8,
    parameter int KICK_PERIODS = 4,
    parameter int TACH_WINDOW  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fan_speed,
    input  logic       enable,
    input  logic       tach_in,
    input  logic       fault_clear,
    output logic       fan_pwm,
    output logic [7:0] duty_current,
    output logic [7:0] tach_count,
    output logic       fan_fault
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int KW = $clog2(KICK_PERIODS + 1);
    localparam int WW = $clog2(TACH_WINDOW + 1);

    typedef enum logic [1:0] {ST_OFF, ST_KICK, ST_RUN, ST_FAULT} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_pre_cnt;
    logic [7:0]      r_pwm_cnt;
    logic [7:0]      r_duty;
    logic [7:0]      w_duty_next;
    logic [KW-1:0]   r_kick_cnt;
    logic [KW-1:0]   w_kick_next;
    logic            r_pwm;
    logic            r_tach_meta;
    logic            r_tach_sync;
    logic            r_tach_prev;
    logic            r_tach_edge;
    logic [7:0]      r_edge_cnt;
    logic [WW-1:0]   r_win_cnt;
    logic [7:0]      r_tach_count;

    logic            w_tick;
    logic            w_period_end;
    logic [7:0]      w_target;
    logic [8:0]      w_up_sum;
    logic [8:0]      w_dn_diff;
    logic [7:0]      w_ramped;
    logic [7:0]      w_edge_total;
    logic            w_win_close;
    logic            w_stall;
    logic            w_clear_tach;

    // ---------------- timebase ----------------
    assign w_tick       = (r_pre_cnt == PW'(PRESCALE - 1));
    assign w_period_end = w_tick && (r_pwm_cnt == 8'd254);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= 8'd0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            // 255 steps per period so that duty 0xFF is a constant high
            r_pwm_cnt <= (r_pwm_cnt == 8'd254) ? 8'd0 : r_pwm_cnt + 8'd1;
        end else begin
            r_pre_cnt <= r_pre_cnt + PW'(1);
        end
    end

    // ---------------- ramp arithmetic ----------------
    assign w_target  = enable ? fan_speed : 8'h00;
    assign w_up_sum  = {1'b0, r_duty} + 9'(RAMP_STEP);
    // bit 8 flags an underflow below zero
    assign w_dn_diff = {1'b0, r_duty} - 9'(RAMP_STEP);

    always_comb begin
        w_ramped = r_duty;
        if (w_target > r_duty) begin
            w_ramped = (w_up_sum > {1'b0, w_target}) ? w_target : w_up_sum[7:0];
        end else if (w_target < r_duty) begin
            w_ramped = (w_dn_diff[8] || (w_dn_diff[7:0] < w_target)) ? w_target : w_dn_diff[7:0];
        end
    end

    // ---------------- tach path ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tach_meta <= 1'b0;
            r_tach_sync <= 1'b0;
            r_tach_prev <= 1'b0;
            r_tach_edge <= 1'b0;
        end else begin
            r_tach_meta <= tach_in;
            r_tach_sync <= r_tach_meta;
            r_tach_prev <= r_tach_sync;
            r_tach_edge <= r_tach_sync & ~r_tach_prev;
        end
    end

    // Edge count including an edge arriving this cycle, so that an edge on the
    // window-closing cycle lands in the closing window.
    assign w_edge_total = (r_edge_cnt == 8'hFF) ? 8'hFF : r_edge_cnt + {7'd0, r_tach_edge};
    assign w_win_close  = (r_state == ST_RUN) && w_period_end && (r_win_cnt == WW'(TACH_WINDOW - 1));
    assign w_stall      = w_win_close && (w_edge_total == 8'd0);
    assign w_clear_tach = ((r_state != ST_RUN) && (w_state_next == ST_RUN)) ||
                          ((r_state == ST_FAULT) && fault_clear);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt   <= 8'd0;
            r_win_cnt    <= '0;
            r_tach_count <= 8'd0;
        end else if (w_clear_tach) begin
            r_edge_cnt <= 8'd0;
            r_win_cnt  <= '0;
        end else if (w_win_close) begin
            r_tach_count <= w_edge_total;
            r_edge_cnt   <= 8'd0;
            r_win_cnt    <= '0;
        end else begin
            r_edge_cnt <= w_edge_total;
            if ((r_state == ST_RUN) && w_period_end) begin
                r_win_cnt <= r_win_cnt + WW'(1);
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_duty     <= 8'h00;
            r_kick_cnt <= '0;
            r_pwm      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_duty     <= w_duty_next;
            r_kick_cnt <= w_kick_next;
            r_pwm      <= (r_pwm_cnt < r_duty) || (r_state == ST_FAULT);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_duty_next  = r_duty;
        w_kick_next  = r_kick_cnt;
        case (r_state)
            ST_OFF: begin
                if (w_period_end && (w_target != 8'h00)) begin
                    w_state_next = ST_KICK;
                    w_duty_next  = 8'hFF;
                    w_kick_next  = KW'(KICK_PERIODS);
                end
            end
            ST_KICK: begin
                if (w_period_end) begin
                    if (w_target == 8'h00) begin
                        w_state_next = ST_OFF;
                        w_duty_next  = 8'h00;
                        w_kick_next  = '0;
                    end else begin
                        w_kick_next = r_kick_cnt - KW'(1);
                        if (r_kick_cnt == KW'(1)) begin
                            // leaving the kick also takes the first ramp step
                            w_state_next = ST_RUN;
                            w_duty_next  = w_ramped;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (w_period_end) begin
                    if (w_stall) begin
                        // stall detection outranks the ramp on the same period end
                        w_state_next = ST_FAULT;
                        w_duty_next  = 8'hFF;
                    end else begin
                        w_duty_next = w_ramped;
                        if ((w_ramped == 8'h00) && (w_target == 8'h00)) begin
                            w_state_next = ST_OFF;
                        end
                    end
                end
            end
            ST_FAULT: begin
                w_duty_next = 8'hFF;
                if (fault_clear) begin
                    w_state_next = ST_OFF;
                    w_duty_next  = 8'h00;
                end
            end
            default: begin
                w_state_next = ST_OFF;
                w_duty_next  = 8'h00;
            end
        endcase
    end

    assign fan_pwm      = r_pwm;
    assign duty_current = r_duty;
    assign tach_count   = r_tach_count;
    assign fan_fault    = (r_state == ST_FAULT);

endmodule
